// File: rtl/i2s_ctrl_pkg.sv
// Shared types for the I2S capture controller: FSM states and channel-select encodings.
package i2s_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] CH_LEFT  = 2'b00;
    localparam logic [1:0] CH_RIGHT = 2'b01;
    localparam logic [1:0] CH_BOTH  = 2'b10;

    // 2'b11 is folded into "both" so every encoding captures something
    function automatic logic chan_match(input logic [1:0] sel, input logic ws);
        return ((sel == CH_LEFT) && !ws) || ((sel == CH_RIGHT) && ws) ||
               (sel == CH_BOTH) || (sel == 2'b11);
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO; a write on full is accepted only when a read frees a slot the same cycle.
module i2s_sample_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S microphone capture controller: gates the receiver, drops the first partial frame,
// filters channels and queues truncated samples for the feature-extraction stage.
//
// state | meaning
// IDLE  | receiver off, FIFO still drainable, waiting for start
// SYNC  | receiver on, discarding the first (partial) word
// RUN   | receiver on, capturing matching words into the FIFO
module i2s_rx_ctrl
    import i2s_ctrl_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                mode_cont,
    input  logic [1:0]          chan_sel,
    input  logic [15:0]         num_samples,
    output logic                rx_en,
    input  logic                rx_done,
    input  logic [31:0]         rx_data,
    input  logic                rx_ws,
    output logic [SAMPLE_W-1:0] smp_data,
    output logic                smp_chan,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [LW-1:0]       level,
    output logic                busy,
    output logic                overrun,
    output logic                done_irq
);

    state_t      state;
    logic        mode_q;
    logic [1:0]  chan_q;
    logic [15:0] remain;
    logic        start_acc;
    logic        accept;
    logic        rd_en;
    logic        fifo_full;
    logic        fifo_empty;
    logic [SAMPLE_W:0] fifo_rd;
    logic        unused_rx;

    assign unused_rx = ^rx_data;
    assign start_acc = start & ~stop & (state == IDLE);
    assign accept    = (state == RUN) & rx_done & ~stop & chan_match(chan_q, rx_ws);
    assign smp_valid = ~fifo_empty;
    assign rd_en     = smp_valid & smp_ready;
    assign smp_chan  = fifo_rd[SAMPLE_W];
    assign smp_data  = fifo_rd[SAMPLE_W-1:0];

    i2s_sample_fifo #(.W(SAMPLE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .wr_en   (accept),
        .wr_data ({rx_ws, rx_data[31 -: SAMPLE_W]}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Sample counter runs down from the latched count; terminal count ends a one-shot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rx_en    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            done_irq <= 1'b0;
            mode_q   <= 1'b0;
            chan_q   <= CH_LEFT;
            remain   <= '0;
        end else begin
            done_irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        overrun <= 1'b0;
                        mode_q  <= mode_cont;
                        chan_q  <= chan_sel;
                        remain  <= num_samples;
                        if (!mode_cont && num_samples == 16'd0) begin
                            done_irq <= 1'b1;
                        end else begin
                            state <= SYNC;
                            rx_en <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (stop) begin
                        state <= IDLE;
                        rx_en <= 1'b0;
                        busy  <= 1'b0;
                    end else if (rx_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        rx_en <= 1'b0;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        if (fifo_full && !rd_en) overrun <= 1'b1;
                        if (!mode_q) begin
                            remain <= remain - 16'd1;
                            if (remain == 16'd1) begin
                                state    <= IDLE;
                                rx_en    <= 1'b0;
                                busy     <= 1'b0;
                                done_irq <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    rx_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl with hand-computed expectations per scenario.
module tb_i2s_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_cont = 1'b0;
    logic [1:0]  chan_sel = 2'b00;
    logic [15:0] num_samples = 16'd0;
    logic        rx_done = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic        rx_ws = 1'b0;
    logic        smp_ready = 1'b0;
    logic        rx_en;
    logic [15:0] smp_data;
    logic        smp_chan;
    logic        smp_valid;
    logic [3:0]  level;
    logic        busy;
    logic        overrun;
    logic        done_irq;

    int tot = 0;
    int bad = 0;

    i2s_rx_ctrl #(.SAMPLE_W(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
        .chan_sel(chan_sel), .num_samples(num_samples), .rx_en(rx_en),
        .rx_done(rx_done), .rx_data(rx_data), .rx_ws(rx_ws),
        .smp_data(smp_data), .smp_chan(smp_chan), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .level(level), .busy(busy), .overrun(overrun),
        .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [1:0] c, input logic [15:0] n);
        start = 1'b1; mode_cont = m; chan_sel = c; num_samples = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic rx_word(input logic ws, input logic [31:0] d);
        rx_done = 1'b1; rx_ws = ws; rx_data = d;
        cyc();
        rx_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        tot++; if ({rx_en, smp_valid, busy, overrun, done_irq} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {rx_en, smp_valid, busy, overrun, done_irq}); end
        tot++; if ({level, smp_data, smp_chan} !== 21'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {level, smp_data, smp_chan}); end
        rst = 1'b0;
        cyc();
        tot++; if ({rx_en, busy, level} !== 6'd0) begin bad++; $display("FAIL reset_release got=%h exp=0", {rx_en, busy, level}); end
    endtask

    task automatic test_oneshot_left();
        smp_ready = 1'b0;
        do_start(1'b0, 2'b00, 16'd4);
        tot++; if ({busy, rx_en} !== 2'b11) begin bad++; $display("FAIL os_start got=%b exp=11", {busy, rx_en}); end
        rx_word(1'b0, 32'hA5A50000);
        tot++; if (level !== 4'd0) begin bad++; $display("FAIL os_discard level got=%0d exp=0", level); end
        for (int i = 1; i <= 8; i++) begin
            rx_word(i[0], 32'hA5A50000 + i);
            tot++; if (level !== 4'(i / 2)) begin bad++; $display("FAIL os_level i=%0d got=%0d exp=%0d", i, level, i / 2); end
            tot++; if ({done_irq, rx_en, busy} !== {(i == 8), (i != 8), (i != 8)}) begin bad++; $display("FAIL os_ctrl i=%0d got=%b", i, {done_irq, rx_en, busy}); end
        end
        cyc();
        tot++; if (done_irq !== 1'b0) begin bad++; $display("FAIL os_irq_low got=%b exp=0", done_irq); end
        smp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tot++; if ({smp_valid, smp_chan, smp_data} !== {1'b1, 1'b0, 16'hA5A5}) begin bad++; $display("FAIL os_read i=%0d got=%b/%b/%h exp=1/0/a5a5", i, smp_valid, smp_chan, smp_data); end
            cyc();
        end
        tot++; if ({smp_valid, level} !== 5'd0) begin bad++; $display("FAIL os_empty got=%b/%0d exp=0/0", smp_valid, level); end
        smp_ready = 1'b0;
    endtask

    task automatic test_continuous_both();
        smp_ready = 1'b1;
        do_start(1'b1, 2'b10, 16'd0);
        rx_word(1'b0, 32'h1111FFFF);
        tot++; if (smp_valid !== 1'b0) begin bad++; $display("FAIL cont_discard got=%b exp=0", smp_valid); end
        for (int i = 0; i < 6; i++) begin
            rx_word(i[0], {16'(16'h2000 + i), 16'hFFFF});
            tot++; if ({smp_valid, smp_chan, smp_data} !== {1'b1, i[0], 16'(16'h2000 + i)}) begin bad++; $display("FAIL cont_sample i=%0d got=%b/%b/%h exp=1/%b/%h", i, smp_valid, smp_chan, smp_data, i[0], 16'h2000 + i); end
            cyc();
            tot++; if (smp_valid !== 1'b0) begin bad++; $display("FAIL cont_drained i=%0d got=%b exp=0", i, smp_valid); end
        end
        stop = 1'b1; rx_done = 1'b1; rx_ws = 1'b0; rx_data = 32'h7777_0000;
        cyc();
        stop = 1'b0; rx_done = 1'b0;
        tot++; if ({rx_en, busy, smp_valid, level} !== 7'd0) begin bad++; $display("FAIL cont_stop got=%b/%b/%b/%0d exp=0", rx_en, busy, smp_valid, level); end
        rx_word(1'b1, 32'h8888_0000);
        tot++; if ({smp_valid, level} !== 5'd0) begin bad++; $display("FAIL cont_after_stop got=%b/%0d exp=0/0", smp_valid, level); end
        smp_ready = 1'b0;
    endtask

    task automatic test_overrun();
        smp_ready = 1'b0;
        do_start(1'b1, 2'b10, 16'd0);
        rx_word(1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            rx_word(i[0], {16'(16'h3000 + i), 16'h0});
            tot++; if (level !== ((i < 8) ? 4'(i + 1) : 4'd8)) begin bad++; $display("FAIL ovr_level i=%0d got=%0d", i, level); end
            tot++; if (overrun !== (i >= 8)) begin bad++; $display("FAIL ovr_flag i=%0d got=%b exp=%b", i, overrun, i >= 8); end
        end
        do_stop();
        smp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tot++; if ({smp_valid, smp_data} !== {1'b1, 16'(16'h3000 + i)}) begin bad++; $display("FAIL ovr_order i=%0d got=%b/%h exp=1/%h", i, smp_valid, smp_data, 16'h3000 + i); end
            cyc();
        end
        smp_ready = 1'b0;
        tot++; if ({overrun, level} !== {1'b1, 4'd0}) begin bad++; $display("FAIL ovr_sticky got=%b/%0d exp=1/0", overrun, level); end
        do_start(1'b1, 2'b10, 16'd0);
        tot++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        rx_word(1'b0, 32'h0);
        rx_word(1'b0, 32'h1234_0000);
        rx_word(1'b1, 32'h5678_0000);
        tot++; if (level !== 4'd2) begin bad++; $display("FAIL ovr_refill got=%0d exp=2", level); end
        do_stop();
        do_start(1'b1, 2'b10, 16'd0);
        tot++; if ({level, smp_valid} !== 5'd0) begin bad++; $display("FAIL start_clears got=%0d/%b exp=0/0", level, smp_valid); end
        do_stop();
    endtask

    task automatic test_full_rw();
        smp_ready = 1'b0;
        do_start(1'b1, 2'b11, 16'd0);
        rx_word(1'b0, 32'h0);
        for (int i = 0; i < 8; i++) rx_word(i[0], {16'(16'h4000 + i), 16'h0});
        tot++; if (level !== 4'd8) begin bad++; $display("FAIL frw_full got=%0d exp=8", level); end
        smp_ready = 1'b1;
        rx_word(1'b0, 32'h4008_0000);
        smp_ready = 1'b0;
        tot++; if ({level, overrun, smp_data} !== {4'd8, 1'b0, 16'h4001}) begin bad++; $display("FAIL frw_rw got=%0d/%b/%h exp=8/0/4001", level, overrun, smp_data); end
        do_stop();
        smp_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tot++; if ({smp_valid, smp_data} !== {1'b1, 16'(16'h4000 + i)}) begin bad++; $display("FAIL frw_order i=%0d got=%b/%h exp=1/%h", i, smp_valid, smp_data, 16'h4000 + i); end
            cyc();
        end
        smp_ready = 1'b0;
    endtask

    task automatic test_zero_count();
        do_start(1'b0, 2'b00, 16'd0);
        tot++; if ({done_irq, rx_en, busy} !== 3'b100) begin bad++; $display("FAIL zero_irq got=%b exp=100", {done_irq, rx_en, busy}); end
        cyc();
        tot++; if ({done_irq, rx_en, busy} !== 3'b000) begin bad++; $display("FAIL zero_after got=%b exp=000", {done_irq, rx_en, busy}); end
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; mode_cont = 1'b1; chan_sel = 2'b10;
        cyc();
        start = 1'b0; stop = 1'b0;
        tot++; if ({busy, rx_en} !== 2'b00) begin bad++; $display("FAIL start_stop got=%b exp=00", {busy, rx_en}); end
    endtask

    task automatic test_start_busy();
        do_start(1'b0, 2'b00, 16'd2);
        start = 1'b1; mode_cont = 1'b1; chan_sel = 2'b01; num_samples = 16'd1;
        cyc();
        start = 1'b0;
        rx_word(1'b0, 32'h0);
        rx_word(1'b1, 32'h5001_0000);
        tot++; if ({level, busy} !== {4'd0, 1'b1}) begin bad++; $display("FAIL busy_chan got=%0d/%b exp=0/1", level, busy); end
        rx_word(1'b0, 32'h5002_0000);
        tot++; if ({level, busy, done_irq} !== {4'd1, 1'b1, 1'b0}) begin bad++; $display("FAIL busy_count got=%0d/%b/%b exp=1/1/0", level, busy, done_irq); end
        rx_word(1'b0, 32'h5003_0000);
        tot++; if ({level, busy, done_irq} !== {4'd2, 1'b0, 1'b1}) begin bad++; $display("FAIL busy_done got=%0d/%b/%b exp=2/0/1", level, busy, done_irq); end
    endtask

    task automatic test_reset_mid();
        do_start(1'b1, 2'b10, 16'd0);
        rx_word(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) rx_word(i[0], 32'h9000_0000 + (32'(i) << 16));
        tot++; if (level !== 4'd3) begin bad++; $display("FAIL rmid_fill got=%0d exp=3", level); end
        #2;
        rst = 1'b1;
        #1;
        tot++; if ({rx_en, smp_valid, busy, overrun, done_irq, level, smp_data, smp_chan} !== 26'd0) begin bad++; $display("FAIL rmid_async got=%h exp=0", {rx_en, smp_valid, busy, overrun, done_irq, level, smp_data, smp_chan}); end
        cyc();
        rst = 1'b0;
        cyc();
        do_start(1'b0, 2'b00, 16'd1);
        tot++; if ({busy, rx_en, level} !== {2'b11, 4'd0}) begin bad++; $display("FAIL rmid_restart got=%b/%b/%0d exp=1/1/0", busy, rx_en, level); end
        rx_word(1'b0, 32'h0);
        rx_word(1'b0, 32'h6789_ABCD);
        tot++; if ({done_irq, level, smp_data, smp_chan} !== {1'b1, 4'd1, 16'h6789, 1'b0}) begin bad++; $display("FAIL rmid_sample got=%b/%0d/%h/%b exp=1/1/6789/0", done_irq, level, smp_data, smp_chan); end
    endtask

    initial begin
        test_reset();
        test_oneshot_left();
        test_continuous_both();
        test_overrun();
        test_full_rw();
        test_zero_count();
        test_start_stop();
        test_start_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
